// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-way registered operand mux.
// Imported by mux_n_comb and mux_n_pipe.
package mux_pkg;

  localparam int MUX_N_MIN = 2;
  localparam int MUX_N_MAX = 16;

  // Select/tag width for an n-way mux, never narrower than 1 bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Pure combinational N:1 select with out-of-range detection.
// An out-of-range select yields zero data and raises err.
module mux_n_comb
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N = 4,
  localparam int SEL_W = sel_width(N)
) (
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   data,
  output logic               err
);

  // Scan all channels; a miss leaves zero data and err set.
  always_comb begin
    data = '0;
    err  = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (sel == SEL_W'(i)) begin
        data = in_data[i*WIDTH +: WIDTH];
        err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// N-way operand mux with a registered valid/ready output stage.
// A 2-entry main/skid buffer absorbs one beat during a stall.
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N = 4,
  localparam int SEL_W = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_ch,
  output logic               sel_err,
  output logic               out_valid,
  input  logic               out_ready
);

  if (N < MUX_N_MIN || N > MUX_N_MAX) begin : g_n_chk
    $error("mux_n_pipe: N must be in 2..16");
  end

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] ch;
    logic             err;
  } beat_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  logic [WIDTH-1:0] sel_data;
  logic             sel_bad;
  beat_t            in_beat;
  beat_t            main_q, main_d;
  beat_t            skid_q, skid_d;
  logic             main_v, main_v_d;
  logic             skid_v, skid_v_d;
  logic             ready_d;
  logic             acc, xfer;
  state_t           state;

  mux_n_comb #(
    .WIDTH(WIDTH),
    .N(N)
  ) u_sel (
    .in_data(in_data),
    .sel(sel),
    .data(sel_data),
    .err(sel_bad)
  );

  assign in_beat = '{data: sel_data, ch: sel, err: sel_bad};
  assign acc     = in_valid & in_ready;
  assign xfer    = main_v & out_ready;

  // Occupancy state follows directly from the two valid bits.
  always_comb begin
    state = EMPTY;
    if (skid_v)      state = FULL;
    else if (main_v) state = ONE;
  end

  // Next buffer contents; flush wins over any accept or transfer.
  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v;
    skid_v_d = skid_v;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (acc) begin
            main_d   = in_beat;
            main_v_d = 1'b1;
          end
        end
        ONE: begin
          if (acc && xfer) begin
            main_d = in_beat;
          end else if (acc) begin
            skid_d   = in_beat;
            skid_v_d = 1'b1;
          end else if (xfer) begin
            main_v_d = 1'b0;
          end
        end
        FULL: begin
          if (xfer) begin
            main_d   = skid_q;
            skid_v_d = 1'b0;
          end
        end
        default: begin
          main_v_d = 1'b0;
          skid_v_d = 1'b0;
        end
      endcase
    end
    ready_d = ~skid_v_d;
  end

  // Buffer registers; reset discards everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v   <= 1'b0;
      skid_v   <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v   <= main_v_d;
      skid_v   <= skid_v_d;
      in_ready <= ready_d;
    end
  end

  assign out_data  = main_q.data;
  assign out_ch    = main_q.ch;
  assign sel_err   = main_q.err;
  assign out_valid = main_v;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: three instances (N=4/32b, N=3/32b, N=5/8b)
// share one stimulus and are checked against a queue model.
module tb_mux_n_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ch [5];
  logic [2:0]  sel = 3'd0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;

  always #5 clk = ~clk;

  logic [31:0] od4, od3;
  logic [7:0]  od5;
  logic [1:0]  oc4, oc3;
  logic [2:0]  oc5;
  logic        oe4, oe3, oe5, ov4, ov3, ov5, ir4, ir3, ir5;

  mux_n_pipe #(.WIDTH(32), .N(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_data({ch[3], ch[2], ch[1], ch[0]}),
    .sel(sel[1:0]), .in_valid(in_valid), .in_ready(ir4),
    .flush(flush), .out_data(od4), .out_ch(oc4), .sel_err(oe4),
    .out_valid(ov4), .out_ready(out_ready)
  );

  mux_n_pipe #(.WIDTH(32), .N(3)) u3 (
    .clk(clk), .rst_n(rst_n),
    .in_data({ch[2], ch[1], ch[0]}),
    .sel(sel[1:0]), .in_valid(in_valid), .in_ready(ir3),
    .flush(flush), .out_data(od3), .out_ch(oc3), .sel_err(oe3),
    .out_valid(ov3), .out_ready(out_ready)
  );

  mux_n_pipe #(.WIDTH(8), .N(5)) u5 (
    .clk(clk), .rst_n(rst_n),
    .in_data({ch[4][7:0], ch[3][7:0], ch[2][7:0], ch[1][7:0], ch[0][7:0]}),
    .sel(sel), .in_valid(in_valid), .in_ready(ir5),
    .flush(flush), .out_data(od5), .out_ch(oc5), .sel_err(oe5),
    .out_valid(ov5), .out_ready(out_ready)
  );

  logic [31:0] od [3];
  logic [3:0]  oc [3];
  logic        oe [3], ov [3], ir [3];

  assign od[0] = od4;
  assign od[1] = od3;
  assign od[2] = {24'd0, od5};
  assign oc[0] = {2'd0, oc4};
  assign oc[1] = {2'd0, oc3};
  assign oc[2] = {1'b0, oc5};
  assign oe[0] = oe4;
  assign oe[1] = oe3;
  assign oe[2] = oe5;
  assign ov[0] = ov4;
  assign ov[1] = ov3;
  assign ov[2] = ov5;
  assign ir[0] = ir4;
  assign ir[1] = ir3;
  assign ir[2] = ir5;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: a 2-deep FIFO with registered ready --------
  typedef struct {
    logic [31:0] d;
    logic [3:0]  c;
    logic        e;
  } mb_t;

  mb_t mq [3][$];
  bit  mrdy [3];
  int  acc_cnt = 0;

  function automatic int nk(int k);
    return (k == 0) ? 4 : ((k == 1) ? 3 : 5);
  endfunction

  function automatic int swk(int k);
    return (k == 2) ? 3 : 2;
  endfunction

  function automatic mb_t ref_beat(int k);
    mb_t r;
    int  s;
    s   = int'(sel) & ((1 << swk(k)) - 1);
    r.c = 4'(s);
    if (s < nk(k)) begin
      r.d = (k == 2) ? (ch[s] & 32'hFF) : ch[s];
      r.e = 1'b0;
    end else begin
      r.d = 32'd0;
      r.e = 1'b1;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        mq[k].delete();
        mrdy[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        bit a, x;
        a = in_valid && mrdy[k];
        x = (mq[k].size() > 0) && out_ready;
        if (flush) begin
          mq[k].delete();
        end else begin
          if (x) void'(mq[k].pop_front());
          if (a) begin
            mq[k].push_back(ref_beat(k));
            if (k == 2) acc_cnt++;
          end
        end
        mrdy[k] = (mq[k].size() < 2);
      end
    end
  end

  // ---------------- per-cycle compare against the model ---------------
  bit          pst = 1'b0;
  bit          pf = 1'b0;
  logic [31:0] pd = '0;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d out_valid", k), 32'(ov[k]), 32'(mq[k].size() > 0));
      chk($sformatf("u%0d in_ready", k), 32'(ir[k]), 32'(mrdy[k]));
      if (mq[k].size() > 0) begin
        chk($sformatf("u%0d out_data", k), od[k], mq[k][0].d);
        chk($sformatf("u%0d out_ch", k), 32'(oc[k]), 32'(mq[k][0].c));
        chk($sformatf("u%0d sel_err", k), 32'(oe[k]), 32'(mq[k][0].e));
      end
    end
    if (pst && rst_n && !pf) chk("u5 hold under stall", od[2], pd);
    pst = ov[2] && !out_ready && rst_n;
    pd  = od[2];
    pf  = flush;
  end

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus with literal pins ----------------
  initial begin
    ch[0] = 32'hAAAA0000;
    ch[1] = 32'hBBBB0001;
    ch[2] = 32'hCCCC0002;
    ch[3] = 32'hDDDD0003;
    ch[4] = 32'hEEEE0004;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    sel       = 3'd0;

    // reset held for three clocks with in_valid high
    repeat (3) begin
      @(negedge clk);
      chk("rst in_ready", 32'(ir[0]), 32'd0);
      chk("rst out_valid", 32'(ov[0]), 32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post-release in_ready low", 32'(ir[0]), 32'd0);
    wait_edge();
    chk("in_ready after first edge", 32'(ir[0]), 32'd1);

    // streaming, one beat per clock
    for (int i = 0; i < 4; i++) begin
      wait_edge();
      chk("stream data", od[0], 32'hAAAA0000 + 32'(i) * 32'h11110001);
      chk("stream ch", 32'(oc[0]), 32'(i));
      sel = 3'(i + 1);
    end
    in_valid = 1'b0;
    wait_edge();

    // stall: main keeps B, skid takes C
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 3'd1;
    wait_edge();
    sel = 3'd2;
    wait_edge();
    chk("stall in_ready", 32'(ir[0]), 32'd0);
    chk("stall main", od[0], 32'hBBBB0001);
    in_valid = 1'b0;
    wait_edge();
    chk("stall hold", od[0], 32'hBBBB0001);
    out_ready = 1'b1;
    wait_edge();
    chk("skid drains", od[0], 32'hCCCC0002);
    wait_edge();
    chk("drained", 32'(ov[0]), 32'd0);

    // out of range on the N=3 instance
    in_valid = 1'b1;
    sel      = 3'd3;
    wait_edge();
    chk("oor data", od[1], 32'd0);
    chk("oor ch", 32'(oc[1]), 32'd3);
    chk("oor err", 32'(oe[1]), 32'd1);
    sel = 3'd0;
    wait_edge();
    chk("after oor err", 32'(oe[1]), 32'd0);
    chk("after oor data", od[1], 32'hAAAA0000);
    in_valid = 1'b0;
    wait_edge();

    // flush in ONE with a same-cycle accept, then in FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 3'd1;
    wait_edge();
    flush = 1'b1;
    sel   = 3'd2;
    wait_edge();
    chk("flush one valid", 32'(ov[0]), 32'd0);
    chk("flush one ready", 32'(ir[0]), 32'd1);
    flush = 1'b0;
    sel   = 3'd1;
    wait_edge();
    sel = 3'd2;
    wait_edge();
    chk("full before flush", 32'(ir[0]), 32'd0);
    flush = 1'b1;
    sel   = 3'd3;
    wait_edge();
    chk("flush full valid", 32'(ov[0]), 32'd0);
    chk("flush full ready", 32'(ir[0]), 32'd1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) wait_edge();
    chk("nothing after flush", 32'(ov[0]), 32'd0);

    // async reset between edges while FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 3'd1;
    wait_edge();
    sel = 3'd2;
    wait_edge();
    in_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async valid", 32'(ov[0]), 32'd0);
    chk("async data", od[0], 32'd0);
    chk("async ch", 32'(oc[0]), 32'd0);
    chk("async err", 32'(oe[0]), 32'd0);
    chk("async ready", 32'(ir[0]), 32'd0);
    chk("async u5 valid", 32'(ov[2]), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_edge();
    chk("ready after reset", 32'(ir[0]), 32'd1);

    // random traffic, 10k beats into the N=5 instance
    acc_cnt = 0;
    for (int cyc = 0; cyc < 40000 && acc_cnt < 10000; cyc++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      sel       = 3'($urandom_range(0, 7));
      for (int i = 0; i < 5; i++) ch[i] = $urandom;
      wait_edge();
    end
    chk("random beat count reached", 32'(acc_cnt >= 10000), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) wait_edge();
    chk("random drained", 32'(ov[2]), 32'd0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
